// File: rtl/lot_occupancy_multi.sv
// Multi-gate parking-lot occupancy tracker: per-gate beam-sequence decoders
// feeding one shared saturating occupancy counter with flags and BCD digits.
module lot_occupancy_multi #(
    parameter int unsigned NUM_GATES = 2,
    parameter int unsigned CAPACITY  = 25,
    localparam int unsigned CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_GATES-1:0] a,
    input  logic [NUM_GATES-1:0] b,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic [NUM_GATES-1:0] enter_pulse,
    output logic [NUM_GATES-1:0] exit_pulse,
    output logic                 reject,
    output logic                 err_under,
    output logic [3:0]           bcd_tens,
    output logic [3:0]           bcd_ones
);

    localparam int unsigned SUM_W = CNT_W + 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6
    } gate_state_e;

    logic [NUM_GATES-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    gate_state_e          state_q [NUM_GATES];
    gate_state_e          state_d [NUM_GATES];
    logic [NUM_GATES-1:0] enter_q, enter_d, exit_q, exit_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d, empty_q, empty_d;
    logic                 reject_q, reject_d, err_under_q, err_under_d;
    logic [SUM_W-1:0]     e_cnt, x_cnt;
    logic signed [SUM_W-1:0] next_cnt;
    logic [7:0]           cnt8;

    // State registers, including the two-stage sensor synchronisers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_s1_q      <= '0;
            a_s2_q      <= '0;
            b_s1_q      <= '0;
            b_s2_q      <= '0;
            for (int i = 0; i < NUM_GATES; i++) state_q[i] <= IDLE;
            enter_q     <= '0;
            exit_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            reject_q    <= 1'b0;
            err_under_q <= 1'b0;
        end else begin
            a_s1_q      <= a;
            a_s2_q      <= a_s1_q;
            b_s1_q      <= b;
            b_s2_q      <= b_s1_q;
            for (int i = 0; i < NUM_GATES; i++) state_q[i] <= state_d[i];
            enter_q     <= enter_d;
            exit_q      <= exit_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            reject_q    <= reject_d;
            err_under_q <= err_under_d;
        end
    end

    // Per-gate direction decoder; exit states mirror entry states with a<->b
    always_comb begin
        enter_d = '0;
        exit_d  = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if ({a_s2_q[i], b_s2_q[i]} == 2'b10)      state_d[i] = EN1;
                    else if ({a_s2_q[i], b_s2_q[i]} == 2'b01) state_d[i] = EX1;
                end
                EN1: case ({a_s2_q[i], b_s2_q[i]})
                    2'b11:   state_d[i] = EN2;
                    2'b10:   state_d[i] = EN1;
                    default: state_d[i] = IDLE;
                endcase
                EN2: case ({a_s2_q[i], b_s2_q[i]})
                    2'b01:   state_d[i] = EN3;
                    2'b10:   state_d[i] = EN1;
                    2'b11:   state_d[i] = EN2;
                    default: state_d[i] = IDLE;
                endcase
                EN3: case ({a_s2_q[i], b_s2_q[i]})
                    2'b00: begin
                        state_d[i] = IDLE;
                        enter_d[i] = 1'b1;
                    end
                    2'b11:   state_d[i] = EN2;
                    2'b01:   state_d[i] = EN3;
                    default: state_d[i] = IDLE;
                endcase
                EX1: case ({a_s2_q[i], b_s2_q[i]})
                    2'b11:   state_d[i] = EX2;
                    2'b01:   state_d[i] = EX1;
                    default: state_d[i] = IDLE;
                endcase
                EX2: case ({a_s2_q[i], b_s2_q[i]})
                    2'b10:   state_d[i] = EX3;
                    2'b01:   state_d[i] = EX1;
                    2'b11:   state_d[i] = EX2;
                    default: state_d[i] = IDLE;
                endcase
                EX3: case ({a_s2_q[i], b_s2_q[i]})
                    2'b00: begin
                        state_d[i] = IDLE;
                        exit_d[i]  = 1'b1;
                    end
                    2'b11:   state_d[i] = EX2;
                    2'b10:   state_d[i] = EX3;
                    default: state_d[i] = IDLE;
                endcase
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Shared counter: net all gates' events first, then clamp to 0..CAPACITY
    always_comb begin
        e_cnt = '0;
        x_cnt = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            e_cnt = e_cnt + SUM_W'(enter_q[i]);
            x_cnt = x_cnt + SUM_W'(exit_q[i]);
        end
        next_cnt    = $signed(SUM_W'(count_q)) + $signed(e_cnt) - $signed(x_cnt);
        count_d     = count_q;
        reject_d    = 1'b0;
        err_under_d = err_under_q;
        if (next_cnt[SUM_W-1]) begin
            count_d     = '0;
            err_under_d = 1'b1;
        end else if (next_cnt > $signed(SUM_W'(CAPACITY))) begin
            count_d  = CNT_W'(CAPACITY);
            reject_d = 1'b1;
        end else begin
            count_d = CNT_W'(next_cnt);
        end
        full_d  = (count_d == CNT_W'(CAPACITY));
        empty_d = (count_d == '0);
    end

    assign cnt8        = 8'(count_q);
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign enter_pulse = enter_q;
    assign exit_pulse  = exit_q;
    assign reject      = reject_q;
    assign err_under   = err_under_q;
    assign bcd_tens    = 4'(cnt8 / 8'd10);
    assign bcd_ones    = 4'(cnt8 % 8'd10);

endmodule

// File: tb/tb_lot_occupancy_multi.sv
// Self-checking bench for lot_occupancy_multi: directed timing scenarios plus
// randomized serial gate traffic checked against an integer occupancy model.
module tb_lot_occupancy_multi;

    localparam int NG  = 2;
    localparam int CAP = 25;

    logic          clk;
    logic          rst;
    logic [NG-1:0] a, b;
    logic [4:0]    count;
    logic          full, empty, reject, err_under;
    logic [NG-1:0] enter_pulse, exit_pulse;
    logic [3:0]    bcd_tens, bcd_ones;

    int n_cmp = 0;
    int n_fail = 0;
    int m_cnt = 0, m_err = 0, m_ent = 0, m_ex = 0, m_rej = 0;
    int mon_ent = 0, mon_ex = 0, mon_rej = 0;

    lot_occupancy_multi #(.NUM_GATES(NG), .CAPACITY(CAP)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .count(count), .full(full),
        .empty(empty), .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
        .reject(reject), .err_under(err_under), .bcd_tens(bcd_tens),
        .bcd_ones(bcd_ones)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Running totals of strobes seen on the outputs
    always @(negedge clk) begin
        mon_ent += $countones(enter_pulse);
        mon_ex  += $countones(exit_pulse);
        mon_rej += int'(reject);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic phase(input int g, input logic [1:0] s, input int n);
        a[g] = s[1];
        b[g] = s[0];
        tick(n);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_cnt));
        chk({tag, ".full"}, 32'(full), 32'(m_cnt == CAP));
        chk({tag, ".empty"}, 32'(empty), 32'(m_cnt == 0));
        chk({tag, ".tens"}, 32'(bcd_tens), 32'(m_cnt / 10));
        chk({tag, ".ones"}, 32'(bcd_ones), 32'(m_cnt % 10));
        chk({tag, ".err"}, 32'(err_under), 32'(m_err));
        chk({tag, ".n_enter"}, 32'(mon_ent), 32'(m_ent));
        chk({tag, ".n_exit"}, 32'(mon_ex), 32'(m_ex));
        chk({tag, ".n_reject"}, 32'(mon_rej), 32'(m_rej));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".count"}, 32'(count), 0);
        chk({tag, ".full"}, 32'(full), 0);
        chk({tag, ".empty"}, 32'(empty), 1);
        chk({tag, ".pulses"}, 32'({enter_pulse, exit_pulse, reject}), 0);
        chk({tag, ".err"}, 32'(err_under), 0);
        chk({tag, ".bcd"}, 32'({bcd_tens, bcd_ones}), 0);
    endtask

    // Complete, serial entry or exit through one gate; model applied on the way
    task automatic do_entry(input int g, input int hold);
        phase(g, 2'b10, hold);
        phase(g, 2'b11, hold);
        phase(g, 2'b01, hold);
        phase(g, 2'b00, 6);
        m_ent++;
        if (m_cnt == CAP) m_rej++;
        else m_cnt++;
    endtask

    task automatic do_exit(input int g, input int hold);
        phase(g, 2'b01, hold);
        phase(g, 2'b11, hold);
        phase(g, 2'b10, hold);
        phase(g, 2'b00, 6);
        m_ex++;
        if (m_cnt == 0) m_err = 1;
        else m_cnt--;
    endtask

    task automatic do_abort(input int g, input int kind, input int hold);
        case (kind)
            0: phase(g, 2'b10, hold);
            1: begin phase(g, 2'b10, hold); phase(g, 2'b11, hold); phase(g, 2'b10, hold); end
            2: begin
                phase(g, 2'b10, hold); phase(g, 2'b11, hold); phase(g, 2'b01, hold);
                phase(g, 2'b11, hold); phase(g, 2'b10, hold);
            end
            3: begin phase(g, 2'b01, hold); phase(g, 2'b11, hold); phase(g, 2'b01, hold); end
            default: phase(g, 2'b01, hold);
        endcase
        phase(g, 2'b00, 6);
    endtask

    initial begin
        int g, op;
        rst = 1'b0;
        a = '0;
        b = '0;
        tick(3);
        check_reset("reset");
        rst = 1'b1;
        tick(3);

        // Single entry at gate 0 with exact strobe timing
        phase(0, 2'b10, 3); phase(0, 2'b11, 3); phase(0, 2'b01, 3);
        a[0] = 1'b0; b[0] = 1'b0;
        tick(2);
        chk("t1.pulse_early", 32'(enter_pulse), 0);
        tick(1);
        chk("t1.pulse", 32'(enter_pulse), 32'b01);
        chk("t1.count_pre", 32'(count), 0);
        tick(1);
        chk("t1.pulse_one_cycle", 32'(enter_pulse), 0);
        m_ent = 1; m_cnt = 1;
        check_state("t1");

        // Exit at gate 1 back to empty
        phase(1, 2'b01, 3); phase(1, 2'b11, 3); phase(1, 2'b10, 3);
        a[1] = 1'b0; b[1] = 1'b0;
        tick(3);
        chk("t2.pulse", 32'(exit_pulse), 32'b10);
        tick(1);
        chk("t2.pulse_one_cycle", 32'(exit_pulse), 0);
        m_ex = 1; m_cnt = 0;
        check_state("t2");

        // Fill to capacity, then one more is rejected
        for (int i = 0; i < CAP; i++) do_entry(i % NG, 3);
        check_state("t3.fill");
        phase(0, 2'b10, 3); phase(0, 2'b11, 3); phase(0, 2'b01, 3);
        a[0] = 1'b0; b[0] = 1'b0;
        tick(4);
        chk("t3.reject", 32'(reject), 1);
        chk("t3.count_sat", 32'(count), CAP);
        tick(1);
        chk("t3.reject_one_cycle", 32'(reject), 0);
        m_ent++; m_rej++;
        check_state("t3");

        // Two entries landing on the same cycle at CAPACITY-1
        do_exit(1, 3);
        check_state("t4.pre");
        a = 2'b11; b = 2'b00; tick(3);
        a = 2'b11; b = 2'b11; tick(3);
        a = 2'b00; b = 2'b11; tick(3);
        a = 2'b00; b = 2'b00;
        tick(3);
        chk("t4.both_pulse", 32'(enter_pulse), 32'b11);
        tick(1);
        chk("t4.reject", 32'(reject), 1);
        chk("t4.full", 32'(full), 1);
        m_ent += 2; m_rej++; m_cnt = CAP;
        tick(3);
        check_state("t4");

        // Full lot, simultaneous entry at gate 0 and exit at gate 1 net out
        a = 2'b01; b = 2'b10; tick(3);
        a = 2'b11; b = 2'b11; tick(3);
        a = 2'b10; b = 2'b01; tick(3);
        a = 2'b00; b = 2'b00;
        tick(3);
        chk("t4b.pulses", 32'({enter_pulse, exit_pulse}), 32'b0110);
        tick(1);
        chk("t4b.no_reject", 32'(reject), 0);
        m_ent++; m_ex++;
        tick(3);
        check_state("t4b");

        // Abort produces nothing; exit while empty sets sticky underflow
        rst = 1'b0; tick(2); rst = 1'b1; tick(2);
        m_cnt = 0; m_err = 0;
        do_abort(0, 1, 3);
        check_state("t5.abort");
        do_exit(1, 3);
        check_state("t5.under");
        do_entry(0, 3);
        check_state("t5.sticky");

        // Reset in the middle of an entry sequence
        for (int i = 0; i < 6; i++) do_entry(0, 3);
        check_state("t6.pre");
        phase(0, 2'b10, 3); phase(0, 2'b11, 3);
        #3 rst = 1'b0;
        #1 check_reset("t6.async");
        @(posedge clk); #1;
        rst = 1'b1;
        m_cnt = 0; m_err = 0;
        tick(3);
        phase(0, 2'b01, 3);
        phase(0, 2'b00, 6);
        check_state("t6.post");

        // Randomized serial traffic
        for (int i = 0; i < 80; i++) begin
            g  = int'($urandom_range(0, NG - 1));
            op = int'($urandom_range(0, 9));
            if (op < 6)      do_entry(g, int'($urandom_range(3, 5)));
            else if (op < 9) do_exit(g, int'($urandom_range(3, 5)));
            else             do_abort(g, int'($urandom_range(0, 4)), int'($urandom_range(3, 5)));
            check_state($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
